// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W      = 16;
    localparam int IMEM_WORD_W      = 16;
    localparam int DEFAULT_MEM_SIZE = 1024;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte frame, packs 16-bit words into the instruction
// RAM and releases the CPU only after the XOR checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   wr_en,
    output logic [IMEM_ADDR_W-1:0] wr_address,
    output logic [IMEM_WORD_W-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    localparam int          IDX_W     = $clog2(MEM_SIZE / 4) + 1;
    localparam logic [16:0] MAX_WORDS = 17'(MEM_SIZE / 4);

    loader_state_t    state, state_n;
    logic [7:0]       len_hi;
    logic [15:0]      len;
    logic [15:0]      len_full;
    logic [7:0]       hi_byte;
    logic [7:0]       chk;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] idx_inc;
    logic             hs;

    assign hs       = rx_valid && rx_ready;
    assign len_full = {len_hi, rx_data};
    assign idx_inc  = index + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rx_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (start) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_n = (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) ? S_ERROR : S_DATA_HI;
            end
            S_DATA_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_n = S_DATA_LO;
            end
            S_DATA_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_n = S_WRITE;
            end
            S_WRITE: state_n = (16'(idx_inc) == len) ? S_CHK : S_DATA_HI;
            S_CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_n = (rx_data == chk) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_n = S_LEN_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_n = S_LEN_HI;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Write port is registered on the DATA_LO handshake so it is valid exactly in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi     <= '0;
            len        <= '0;
            hi_byte    <= '0;
            chk        <= '0;
            index      <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        chk        <= '0;
                        index      <= '0;
                        wr_address <= '0;
                    end
                end
                S_LEN_HI: if (hs) len_hi <= rx_data;
                S_LEN_LO: if (hs) len <= len_full;
                S_DATA_HI: begin
                    if (hs) begin
                        hi_byte <= rx_data;
                        chk     <= chk ^ rx_data;
                    end
                end
                S_DATA_LO: begin
                    if (hs) begin
                        chk        <= chk ^ rx_data;
                        wr_en      <= 1'b1;
                        wr_address <= IMEM_ADDR_W'({index, 2'b00});
                        wr_data    <= {hi_byte, rx_data};
                    end
                end
                S_WRITE: index <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-frame bench with a write scoreboard for imem_loader.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [15:0] wr_address;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          checks   = 0;
    int          failures = 0;
    int          wr_total = 0;
    int          wr_base;
    logic [15:0] last_addr = 16'h0;
    logic [31:0] exp_q[$];
    logic [15:0] prog[0:255];

    imem_loader #(.MEM_SIZE(1024)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the next expected {address, data}.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_total++;
            last_addr = wr_address;
            chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h required=none", {wr_address, wr_data});
            end else begin
                chk("write", {wr_address, wr_data}, exp_q.pop_front());
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t = 0;
        int k = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1 && k < 4) begin
                rx_valid = 1'b0;
                k++;
                @(posedge clk); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!rx_ready && t < 200);
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout actual=rx_ready_low required=rx_ready_high");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame(input int n_len, input int n_send, input logic [7:0] cks,
                         input bit stall, input int glitch, input bit send_chk);
        logic [15:0] l;
        l = 16'(n_len);
        pulse_start();
        send_byte(l[15:8], stall);
        send_byte(l[7:0], stall);
        for (int i = 0; i < n_send; i++) begin
            exp_q.push_back({16'(4 * i), prog[i]});
            send_byte(prog[i][15:8], stall);
            if (i == glitch) pulse_start();
            send_byte(prog[i][7:0], stall);
        end
        if (send_chk) send_byte(cks, stall);
    endtask

    function automatic logic [7:0] xsum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ prog[i][15:8] ^ prog[i][7:0];
        return x;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_address"}, 32'(wr_address), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic check_end(input string tag, input bit d, input bit e, input int nwr);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!d));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_writes"}, 32'(wr_total - wr_base), 32'(nwr));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic two-word load from the frame example
        prog[0] = 16'h1234; prog[1] = 16'hABCD;
        wr_base = wr_total;
        frame(2, 2, 8'h40, 1'b0, -1, 1'b1);
        check_end("n2_ok", 1'b1, 1'b0, 2);

        wr_base = wr_total;
        frame(2, 2, 8'h41, 1'b0, -1, 1'b1);
        check_end("n2_badchk", 1'b0, 1'b1, 2);

        wr_base = wr_total;
        frame(0, 0, 8'h00, 1'b0, -1, 1'b0);
        check_end("n0", 1'b0, 1'b1, 0);

        wr_base = wr_total;
        frame(257, 0, 8'h00, 1'b0, -1, 1'b0);
        check_end("n257", 1'b0, 1'b1, 0);

        // Full-capacity load with a stalling source
        for (int i = 0; i < 256; i++) prog[i] = 16'(i * 16'h0107) ^ 16'hC35A;
        wr_base = wr_total;
        frame(256, 256, xsum(256), 1'b1, -1, 1'b1);
        check_end("n256_stall", 1'b1, 1'b0, 256);
        chk("n256_last_addr", 32'(last_addr), 32'h0000_03FC);

        // Asynchronous reset after three of five words
        for (int i = 0; i < 5; i++) prog[i] = 16'h1111 * 16'(i + 1) + 16'h0F0F;
        wr_base = wr_total;
        frame(5, 3, 8'h00, 1'b0, -1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        chk("midreset_writes", 32'(wr_total - wr_base), 32'd3);
        chk("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wr_base = wr_total;
        frame(5, 5, xsum(5), 1'b0, -1, 1'b1);
        check_end("after_reset", 1'b1, 1'b0, 5);

        // start pulsed while waiting for a low byte must be ignored
        wr_base = wr_total;
        frame(5, 5, xsum(5), 1'b0, 2, 1'b1);
        check_end("start_in_data_lo", 1'b1, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: receives a program as a byte stream, packs it into 16-bit instruction words, and writes them through the writable port of the instruction RAM at word-aligned byte addresses. It holds the CPU in reset while loading and verifies an XOR checksum before releasing it. It sits between the host byte link (UART receiver or testbench) and the instruction RAM write port, and complements the CPU's read-only fetch path.

## Interface
- MEM_SIZE, 1024: instruction memory size in bytes; power of two, > 4; capacity MEM_SIZE/4 words.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  one-cycle pulse that begins a load session.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts rx_data this cycle.
- wr_en  out  1  instruction RAM write strobe.
- wr_address  out  16  byte address; bits [1:0] always 0.
- wr_data  out  16  instruction word.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  load completed and checksum matched.
- error  out  1  load rejected: bad length or checksum mismatch.

## Operation
- Frame: LEN_HI, LEN_LO (word count N, big-endian), then N×(HI byte, LO byte), then one checksum byte = XOR of all 2N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR.
- IDLE/DONE/ERROR: start → LEN_HI; clear the checksum register, word index and address. start in any other state is ignored.
- LEN_HI → LEN_LO → (N==0 or N > MEM_SIZE/4 ? ERROR : DATA_HI). Each transition happens on a handshake.
- DATA_HI: latch the high byte. DATA_LO: latch the low byte, then go to WRITE.
- WRITE (one cycle): wr_en=1 with wr_address = 4×index and wr_data = {hi,lo}. Then index++. If index==N, go to CHK; otherwise go to DATA_HI.
- CHK: on handshake, if byte == running XOR go to DONE, else go to ERROR.
- Checksum register: 8 bits, updated with every data byte accepted. The length and checksum bytes are excluded.
- cpu_hold=1 in every state except IDLE and DONE. In ERROR it stays 1 so a partial program never runs.
- done=1 only in DONE; error=1 only in ERROR. Both clear when start moves the block to LEN_HI.
- Reset mid-session: returns to IDLE. Words already written stay in RAM and are not rolled back.

## Timing
- Handshake: a byte is consumed on a posedge where rx_valid && rx_ready.
- rx_ready is a Moore output, decoded from state only. It is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK, and 0 elsewhere (including WRITE).
- rx_data must be held stable while rx_valid=1 && rx_ready=0.
- wr_en, wr_address and wr_data are registered. They are valid in the WRITE cycle, and the RAM captures them on the following posedge.
- Peak throughput: 3 cycles per word. Minimum session length for N words is 2 + 3N + 1 handshake/write cycles.
- DONE/ERROR are reached one posedge after the CHK or LEN_LO handshake.
- Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_address=0, wr_data=0, cpu_hold=0, done=0, error=0.
- Max N (MEM_SIZE/4 = 256) writes last word at address MEM_SIZE-4 (0x3FC). The address never wraps.

## Structure
- imem_loader_pkg holds:
  - the state enum `loader_state_t`;
  - `IMEM_ADDR_W = 16` and `IMEM_WORD_W = 16`;
  - the default MEM_SIZE.
- Single module, no sub-modules. Byte packing, counter and XOR are small enough to live inline beside the FSM.

## Test plan
- Load N=2, bytes 00 02 12 34 AB CD 40:
  - writes 0x1234 at address 0x000 and 0xABCD at 0x004;
  - done=1, cpu_hold drops to 0.
- Same frame with checksum 0x41: both writes occur, then error=1 and cpu_hold stays 1.
- N=0 (00 00), and N=257 with MEM_SIZE=1024 (01 01): error=1 after LEN_LO, with no wr_en pulses.
- Stalled source: rx_valid toggles randomly across a 256-word load.
  - Every word is written exactly once at 4×index, last at 0x3FC.
  - rx_ready is never high in WRITE.
- Reset asserted asynchronously after 3 of 5 words: outputs return to reset values immediately.
  - A following start plus a full frame completes with done=1.
- start pulsed during DATA_LO: ignored, and the session completes normally.
